mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 152 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register map, STATUS layout
// and transmit FSM state encoding.
package uart_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_CNT_W   = 7;

    localparam int unsigned CTRL_IRQ_EN  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; pop takes priority so a
// push into a full FIFO is accepted in the same cycle as a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores bytes into a FIFO which the
// bit-timing FSM drains LSB first, with STATUS/CTRL registers and a level irq.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        irq
);

    import uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t       state;
    tx_state_t       state_nxt;
    logic [15:0]     bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            bit_done;

    logic            wr_txdata;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_head;
    logic [CW-1:0]   fifo_count;

    logic            ovf;
    logic            irq_en;
    logic [31:0]     status_word;
    logic [31:0]     rd_mux;

    assign wr_txdata = wr_en && (wr_addr == ADDR_TXDATA);
    assign bit_done  = (state != ST_IDLE) && (bit_cnt == 16'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_txdata),
        .wr_data (wr_data[7:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: if (bit_done) state_nxt = ST_DATA;
            ST_DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP: begin
                // Chain straight into the next start bit when more data waits
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx  = 1'b1;
        irq = irq_en && fifo_empty && (state == ST_IDLE);
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == ST_IDLE || bit_done) bit_cnt <= '0;
            else                              bit_cnt <= bit_cnt + 16'd1;
            if (fifo_pop) begin
                shreg   <= fifo_head;
                bit_idx <= '0;
            end else if (state == ST_DATA && bit_done) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = (state != ST_IDLE);
        status_word[STAT_OVF]   = ovf;
        status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        case (rd_addr)
            ADDR_STATUS: rd_mux = status_word;
            ADDR_CTRL:   rd_mux = {31'd0, irq_en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            irq_en  <= 1'b0;
            rd_data <= '0;
        end else begin
            // A dropped byte outranks a same-cycle clear
            if (wr_txdata && fifo_full && !fifo_pop)
                ovf <= 1'b1;
            else if (wr_en && wr_addr == ADDR_STATUS && wr_data[STAT_OVF])
                ovf <= 1'b0;
            if (wr_en && wr_addr == ADDR_CTRL)
                irq_en <= wr_data[CTRL_IRQ_EN];
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a line receiver checks decoded frames against a
// scoreboard of accepted bytes; scenario tasks check timing and registers.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .irq     (irq)
    );

    // Line receiver: samples mid-bit on falling clock edges
    bit         mon_active = 1'b0;
    int         mon_cyc = 0;
    logic [9:0] mon_bits = '0;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
            end
        end else begin
            mon_cyc++;
            if (mon_cyc % 4 == 2) mon_bits[mon_cyc / 4] = tx;
            if (mon_cyc == 39) begin
                mon_active = 1'b0;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: got frame %03h, expected no frame", mon_bits);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_bits !== {1'b1, mon_exp, 1'b0}) begin
                        n_fail++;
                        $display("FAIL frame_data: got frame %03h, expected %03h",
                                 mon_bits, {1'b1, mon_exp, 1'b0});
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [1:0] a, input logic [31:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (a == 2'd0 && accept) sb.push_back(d[7:0]);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while ((sb.size() != 0 || mon_active) && c < max_cyc) begin
            tick(1);
            c++;
        end
        tick(2);
        n_checks++;
        if (c >= max_cyc) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes outstanding after %0d cycles, expected 0",
                     sb.size(), max_cyc);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0;
        #2;
        n_checks += 3;
        if (tx !== 1'b1)     begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        if (irq !== 1'b0)    begin n_fail++; $display("FAIL reset_irq: got %b, expected 0", irq); end
        if (rd_data !== '0)  begin n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", rd_data); end
        tick(3);
        rst_n = 1'b1;
        tick(1);
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h, expected 00000000", d); end
        store(2'd3, 32'hFFFF_FFFF, 1'b0);
        read_reg(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h, expected 00000000", d); end
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h, expected 00000002", d); end
        tick(3);
        n_checks++;
        if (rd_data !== 32'h2) begin n_fail++; $display("FAIL rd_data_hold: got %h, expected 00000002", rd_data); end
    endtask

    task automatic test_single;
        logic [9:0]  frame;
        logic [31:0] d;
        frame = {1'b1, 8'h55, 1'b0};
        store(2'd0, 32'hFFFF_FF55, 1'b1);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_accept_edge_tx: got %b, expected 1", tx); end
        tick(1);
        for (int c = 0; c < 40; c++) begin
            n_checks += 2;
            if (tx !== frame[c / 4]) begin
                n_fail++;
                $display("FAIL single_line c=%0d: got %b, expected %b", c, tx, frame[c / 4]);
            end
            if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq c=%0d: got %b, expected 0", c, irq); end
            tick(1);
        end
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx: got %b, expected 1", tx); end
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL single_status_idle: got %h, expected 00000002", d); end
        wait_drain(100);
    endtask

    task automatic test_back_to_back;
        logic [19:0] pair;
        pair = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
        store(2'd0, 32'h0000_00A3, 1'b1);
        store(2'd0, 32'h0000_000F, 1'b1);
        for (int c = 0; c < 80; c++) begin
            n_checks++;
            if (tx !== pair[c / 4]) begin
                n_fail++;
                $display("FAIL b2b_line c=%0d: got %b, expected %b", c, tx, pair[c / 4]);
            end
            tick(1);
        end
        wait_drain(100);
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        store(2'd0, 32'h11, 1'b1);
        for (int i = 0; i < 9; i++) store(2'd0, 32'h20 + i, (i < 8));
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h8D) begin n_fail++; $display("FAIL ovf_status_full: got %h, expected 0000008d", d); end
        store(2'd1, 32'h8, 1'b0);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h85) begin n_fail++; $display("FAIL ovf_cleared: got %h, expected 00000085", d); end
        wait_drain(9 * 40 + 40);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL ovf_drained: got %h, expected 00000002", d); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        store(2'd2, 32'h1, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b, expected 1", irq); end
        read_reg(2'd2, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL irq_ctrl_read: got %h, expected 00000001", d); end
        store(2'd0, 32'h3C, 1'b1);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_accept_edge: got %b, expected 0", irq); end
        for (int c = 0; c < 40; c++) begin
            tick(1);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_busy c=%0d: got %b, expected 0", c, irq); end
        end
        tick(1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_stop: got %b, expected 1", irq); end
        store(2'd2, 32'h0, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable: got %b, expected 0", irq); end
        wait_drain(100);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        store(2'd0, 32'hF0, 1'b1);
        tick(1);
        tick(17);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3_pre: got %b, expected 0", tx); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (tx !== 1'b1)    begin n_fail++; $display("FAIL mid_reset_tx: got %b, expected 1", tx); end
        if (irq !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_irq: got %b, expected 0", irq); end
        if (rd_data !== '0) begin n_fail++; $display("FAIL mid_reset_rd: got %h, expected 0", rd_data); end
        sb.delete();
        tick(3);
        rst_n = 1'b1;
        tick(1);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL mid_reset_status: got %h, expected 00000002", d); end
        for (int c = 0; c < 50; c++) begin
            n_checks++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_no_resume c=%0d: got %b, expected 1", c, tx); end
            tick(1);
        end
    endtask

    task automatic test_full_pop;
        logic [31:0] d;
        store(2'd0, 32'hC0, 1'b1);
        for (int i = 0; i < 8; i++) store(2'd0, 32'hC1 + i, 1'b1);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h85) begin n_fail++; $display("FAIL fullpop_pre: got %h, expected 00000085", d); end
        tick(31);
        store(2'd0, 32'hD0, 1'b1);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h85) begin n_fail++; $display("FAIL fullpop_post: got %h, expected 00000085", d); end
        wait_drain(9 * 40 + 40);
        read_reg(2'd1, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL fullpop_drained: got %h, expected 00000002", d); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_reset_mid();
        test_full_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
